// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one external WIDTH-bit adder among NUM_REQ requesters.
// Latency: grant in cycle T, operands on adder in T+1, tagged response valid from T+2; one op in flight.
// Backpressure: response held stable until rsp_ready; no new grant is issued until it is accepted.
module adder_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32,
    parameter int ID_W    = 2,
    parameter int CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [WIDTH-1:0]         adder_a,
    output logic [WIDTH-1:0]         adder_b,
    input  logic [WIDTH-1:0]         adder_y,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_y,
    output logic [ID_W-1:0]          rsp_id,
    output logic                     busy,
    output logic [CNT_W-1:0]         op_count
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t            state;
    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   id_reg;
    logic [ID_W-1:0]   grant_idx;
    logic [ID_W-1:0]   next_ptr;
    logic              grant_found;
    logic [WIDTH-1:0]  op_a;
    logic [WIDTH-1:0]  op_b;
    logic [WIDTH-1:0]  y_reg;
    logic              rsp_valid_q;
    logic              busy_q;

    // First valid requester at or after ptr, wrapping modulo NUM_REQ.
    always_comb begin
        logic [ID_W-1:0] cand;
        cand        = '0;
        grant_idx   = '0;
        grant_found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = ID_W'((int'(ptr) + k) % NUM_REQ);
            if (!grant_found && req_valid[cand]) begin
                grant_idx   = cand;
                grant_found = 1'b1;
            end
        end
    end

    assign next_ptr = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

    // Ready is masked by reset so nothing handshakes while reset is held.
    always_comb begin
        req_ready = '0;
        if (reset && (state == IDLE) && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            ptr         <= '0;
            op_a        <= '0;
            op_b        <= '0;
            y_reg       <= '0;
            id_reg      <= '0;
            op_count    <= '0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        op_a   <= req_a[int'(grant_idx)*WIDTH +: WIDTH];
                        op_b   <= req_b[int'(grant_idx)*WIDTH +: WIDTH];
                        id_reg <= grant_idx;
                        ptr    <= next_ptr;
                        state  <= EXEC;
                        busy_q <= 1'b1;
                    end
                end
                EXEC: begin
                    y_reg       <= adder_y;
                    state       <= RESP;
                    rsp_valid_q <= 1'b1;
                end
                RESP: begin
                    if (rsp_ready) begin
                        op_count    <= op_count + 1'b1;
                        state       <= IDLE;
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    rsp_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign adder_a   = op_a;
    assign adder_b   = op_b;
    assign rsp_valid = rsp_valid_q;
    assign rsp_y     = y_reg;
    assign rsp_id    = id_reg;
    assign busy      = busy_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized requesters and rsp_ready.
module tb_adder_arbiter;

    localparam int NR = 4;
    localparam int W  = 32;
    localparam int IW = 2;
    localparam int CW = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [NR-1:0]     req_valid = '0;
    logic [NR*W-1:0]   req_a = '0;
    logic [NR*W-1:0]   req_b = '0;
    logic              rsp_ready = 1'b0;
    logic [NR-1:0]     req_ready;
    logic [W-1:0]      adder_a;
    logic [W-1:0]      adder_b;
    logic [W-1:0]      adder_y;
    logic              rsp_valid;
    logic [W-1:0]      rsp_y;
    logic [IW-1:0]     rsp_id;
    logic              busy;
    logic [CW-1:0]     op_count;

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 1'b0;

    adder_arbiter #(.NUM_REQ(NR), .WIDTH(W), .ID_W(IW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .adder_a(adder_a), .adder_b(adder_b), .adder_y(adder_y),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y), .rsp_id(rsp_id),
        .busy(busy), .op_count(op_count)
    );

    // The shared adder itself: plain modulo-2^W sum.
    assign adder_y = adder_a + adder_b;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [NR-1:0] rr_pick(input int p, input logic [NR-1:0] v);
        logic [NR-1:0] r;
        bit done;
        r = '0;
        done = 1'b0;
        for (int k = 0; k < NR; k++) begin
            if (!done && v[(p + k) % NR]) begin
                r[(p + k) % NR] = 1'b1;
                done = 1'b1;
            end
        end
        return r;
    endfunction

    // Reference model: the one operation in flight and its age in cycles since grant.
    int          m_ptr    = 0;
    bit          m_active = 1'b0;
    int          m_age    = 0;
    int          m_id     = 0;
    logic [W-1:0]  m_opa  = '0;
    logic [W-1:0]  m_opb  = '0;
    logic [CW-1:0] m_count = '0;

    always @(posedge clk) begin
        logic [NR-1:0] g;
        if (!reset) begin
            m_ptr = 0; m_active = 1'b0; m_age = 0; m_id = 0;
            m_opa = '0; m_opb = '0; m_count = '0;
        end else if (!m_active) begin
            g = rr_pick(m_ptr, req_valid);
            for (int i = 0; i < NR; i++) begin
                if (g[i]) begin
                    m_id     = i;
                    m_opa    = req_a[i*W +: W];
                    m_opb    = req_b[i*W +: W];
                    m_ptr    = (i + 1) % NR;
                    m_active = 1'b1;
                    m_age    = 1;
                end
            end
        end else if (m_age == 1) begin
            m_age = 2;
        end else if (rsp_ready) begin
            m_count  = m_count + 1'b1;
            m_active = 1'b0;
        end
    end

    always @(negedge clk) begin
        logic [NR-1:0] er;
        logic [W-1:0]  es;
        bit            ev;
        if (chk_en) begin
            er = '0;
            if (reset && !m_active) er = rr_pick(m_ptr, req_valid);
            ev = m_active && (m_age == 2);
            es = m_opa + m_opb;
            chk("req_ready", 64'(req_ready), 64'(er));
            chk("busy", 64'(busy), 64'(m_active));
            chk("rsp_valid", 64'(rsp_valid), 64'(ev));
            chk("adder_a", 64'(adder_a), 64'(m_opa));
            chk("adder_b", 64'(adder_b), 64'(m_opb));
            chk("op_count", 64'(op_count), 64'(m_count));
            if (ev) begin
                chk("rsp_y", 64'(rsp_y), 64'(es));
                chk("rsp_id", 64'(rsp_id), 64'(m_id));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_valid[i]       = 1'b1;
        req_a[i*W +: W]    = a;
        req_b[i*W +: W]    = b;
    endtask

    // One full transaction for requester i with rsp_ready held high; waits are bounded.
    task automatic do_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] y, output int id);
        bit seen;
        y = '0;
        id = -1;
        set_req(i, a, b);
        rsp_ready = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            at_neg();
            if (req_ready[i]) seen = 1'b1;
            else tick();
        end
        n_checks++;
        if (!seen) begin
            n_err++;
            $display("FAIL grant_wait: requester %0d got no grant within 20 cycles", i);
        end
        tick();
        req_valid[i] = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            at_neg();
            if (rsp_valid) begin
                seen = 1'b1;
                y = rsp_y;
                id = int'(rsp_id);
            end
            tick();
        end
        n_checks++;
        if (!seen) begin
            n_err++;
            $display("FAIL rsp_wait: no response for requester %0d within 10 cycles", i);
        end
    endtask

    function automatic logic [W-1:0] rand_op();
        case ($urandom_range(0, 4))
            0: return 32'hFFFF_FFFF;
            1: return 32'h8000_0000;
            2: return W'($urandom_range(0, 15));
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        logic [W-1:0]  y;
        int            id;
        logic [NR-1:0] hs;

        // Reset held with every requester valid
        reset = 1'b0;
        req_valid = '1;
        tick();
        chk_en = 1'b1;
        tick();
        at_neg();
        chk("rst_req_ready", 64'(req_ready), 64'h0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_adder_a", 64'(adder_a), 64'h0);
        chk("rst_adder_b", 64'(adder_b), 64'h0);
        chk("rst_op_count", 64'(op_count), 64'h0);
        tick();
        reset = 1'b1;
        at_neg();
        chk("rel_req_ready", 64'(req_ready), 64'b0001);
        #1;
        req_valid = '0;

        // Single op from requester 2
        tick();
        set_req(2, 32'd1, 32'd2);
        rsp_ready = 1'b1;
        at_neg();
        chk("single_grant", 64'(req_ready), 64'b0100);
        tick();
        req_valid = '0;
        at_neg();
        chk("single_adder_a", 64'(adder_a), 64'd1);
        chk("single_adder_b", 64'(adder_b), 64'd2);
        tick();
        at_neg();
        chk("single_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("single_rsp_y", 64'(rsp_y), 64'd3);
        chk("single_rsp_id", 64'(rsp_id), 64'd2);
        tick();
        at_neg();
        chk("single_op_count", 64'(op_count), 64'd1);

        // Round robin with all requesters valid, from a fresh ptr
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int i = 0; i < NR; i++) set_req(i, W'(i), 32'd10);
        for (int k = 0; k < 5; k++) begin
            at_neg();
            chk("rr_grant", 64'(req_ready), 64'(1 << (k % NR)));
            tick();
            tick();
            at_neg();
            chk("rr_rsp_y", 64'(rsp_y), 64'((k % NR) + 10));
            chk("rr_rsp_id", 64'(rsp_id), 64'(k % NR));
            tick();
        end
        req_valid = '0;

        // Backpressure in RESP while requester 0 waits
        set_req(1, 32'd5, 32'd7);
        rsp_ready = 1'b0;
        at_neg();
        chk("bp_grant", 64'(req_ready), 64'b0010);
        tick();
        req_valid = '0;
        set_req(0, 32'd100, 32'd23);
        tick();
        for (int k = 0; k < 5; k++) begin
            at_neg();
            chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
            chk("bp_rsp_y", 64'(rsp_y), 64'd12);
            chk("bp_rsp_id", 64'(rsp_id), 64'd1);
            chk("bp_busy", 64'(busy), 64'd1);
            chk("bp_req_ready", 64'(req_ready), 64'd0);
            tick();
        end
        rsp_ready = 1'b1;
        chk("bp_count_before", 64'(op_count), 64'd5);
        tick();
        at_neg();
        chk("bp_count_after", 64'(op_count), 64'd6);
        chk("bp_rsp_dropped", 64'(rsp_valid), 64'd0);
        chk("bp_next_grant", 64'(req_ready), 64'b0001);
        tick();
        req_valid = '0;
        tick();
        at_neg();
        chk("bp_next_sum", 64'(rsp_y), 64'd123);
        tick();

        // Wraparound sums
        do_op(0, 32'hFFFF_FFFF, 32'h1, y, id);
        chk("wrap_ones", 64'(y), 64'h0);
        do_op(3, 32'h8000_0000, 32'h8000_0000, y, id);
        chk("wrap_msb", 64'(y), 64'h0);
        chk("wrap_msb_id", 64'(id), 64'd3);
        do_op(1, 32'h1234_5678, 32'h1111_1111, y, id);
        chk("plain_sum", 64'(y), 64'h2345_6789);

        // Reset during EXEC drops the operation
        reset = 1'b0;
        tick();
        reset = 1'b1;
        set_req(2, 32'd9, 32'd9);
        at_neg();
        chk("mid_grant", 64'(req_ready), 64'b0100);
        tick();
        req_valid = '0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        set_req(1, 32'd4, 32'd4);
        set_req(3, 32'd6, 32'd6);
        at_neg();
        chk("mid_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("mid_op_count", 64'(op_count), 64'd0);
        chk("mid_after_grant", 64'(req_ready), 64'b0010);
        tick();
        req_valid[1] = 1'b0;
        tick();
        at_neg();
        chk("mid_rsp_id", 64'(rsp_id), 64'd1);
        tick();
        at_neg();
        chk("mid_second_grant", 64'(req_ready), 64'b1000);
        tick();
        req_valid = '0;
        tick();
        tick();

        // Randomized requesters, response backpressure and occasional reset
        for (int c = 0; c < 3000; c++) begin
            at_neg();
            hs = req_valid & req_ready;
            tick();
            reset     = ($urandom_range(0, 299) != 0);
            rsp_ready = ($urandom_range(0, 2) != 0);
            for (int i = 0; i < NR; i++) begin
                if (hs[i]) req_valid[i] = 1'b0;
                if (!req_valid[i] && $urandom_range(0, 2) == 0) set_req(i, rand_op(), rand_op());
            end
        end
        reset = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (4) tick();
        at_neg();
        chk_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
